boc_trk_corr: RTL and testbench
===============================

# boc_trk_corr

Early/prompt/late tracking correlator for the B1 BOC channel. Sits directly downstream of the acquisition/local-code stage and consumes:
- the carrier-wiped baseband samples (real/imag, 16-bit);
- the E/P/L local BOC chips;
- the code start-of-period strobe and the tracking reset.

It integrates six signed correlations (I/Q × E/P/L) over a programmable number of code periods. Each integration result goes to the loop-filter stage through a valid/ready dump handshake.

## Interface
Parameters:
- ACC_WIDTH, 32: accumulator and dump output width, signed.
- SRC_DLY, 2: cycles by which code/sop/trk_rst inputs are delayed to align with rx_src_* (multiplier latency); legal 0–7.
- INT_EPOCHS, 1: code periods per integration; legal 1–20.

Ports (one clock; reset is asynchronous and active-low):
- rx_clk  in  1  sample clock.
- rx_rst_n  in  1  asynchronous active-low reset.
- rx_src_real  in  16  signed in-phase sample.
- rx_src_imag  in  16  signed quadrature sample.
- rx_loc_bocE / rx_loc_bocP / rx_loc_bocL  in  1 each  local BOC chip; 0 → +1, 1 → −1.
- rx_prn_sop  in  1  one-cycle strobe marking the first sample of a code period.
- rx_trk_rst  in  1  synchronous restart of tracking.
- rx_dump_ready  in  1  loop filter accepts the dump.
- tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql  out  ACC_WIDTH each  registered integration results.
- tx_dump_valid  out  1  dump results valid.
- tx_epoch_cnt  out  16  dumps produced since last restart; wraps 65535→0.
- tx_ovf  out  1  sticky; a dump was overwritten before acceptance.

## Operation
- Alignment:
  - rx_loc_boc*, rx_prn_sop and rx_trk_rst pass through a SRC_DLY-stage shift register.
  - All logic below uses the delayed ("aligned") versions.
- Sign extension: samples are sign-extended to ACC_WIDTH.
- Per lane: term = chip ? −sample : +sample.
  - −(−32768) is +32768; this is representable because ACC_WIDTH ≥ 17.
- States:
  - WAIT_SOP (reset/restart): accumulators held at 0.
    - Aligned sop → ACC; accumulators load the current term; period counter = 1.
  - ACC: accumulators add term every cycle.
    - Aligned sop with period counter < INT_EPOCHS: keep accumulating and increment the counter.
    - Aligned sop with period counter == INT_EPOCHS: dump. The output registers load the accumulator values excluding the sop sample. Accumulators load the sop sample's term. Counter = 1.
- Dump handshake:
  - tx_dump_valid asserts the cycle after the dump and holds until a cycle with rx_dump_ready=1.
  - While valid, the tx_* data registers are stable.
  - Transfer occurs on valid&&ready; valid drops the next cycle unless a new dump lands in the same cycle.
- Dump on the accept cycle: a dump and an accept in the same cycle → new data loads, valid stays 1, tx_ovf unchanged.
- Dump while pending: a dump while valid=1 and ready=0 → data overwritten, valid stays 1, tx_ovf set.
- tx_epoch_cnt: increments on every dump.
- Aligned rx_trk_rst:
  - Effects: accumulators and period counter → 0, state → WAIT_SOP, tx_dump_valid → 0, tx_ovf → 0, tx_epoch_cnt → 0.
  - The delay pipeline itself is not flushed.
  - Priority: trk_rst has priority over a coincident sop; that sop is ignored.
- Reset (rx_rst_n low): all outputs 0, state WAIT_SOP, delay pipeline 0. Reset asserted mid-integration discards all partial sums.

## Timing
- tx_dump_valid rises SRC_DLY+1 cycles after the rx_prn_sop that closes the INT_EPOCHS-th period.
- Data and valid are registered outputs; there is no combinational path from rx_dump_ready to any output.
- rx_trk_rst takes effect on outputs SRC_DLY+1 cycles after assertion.
- Throughput: one sample per cycle, no stalls; rx_dump_ready never back-pressures the sample stream.

## Configuration
- BOC_TRK_SAT_EN:
  - Defined: each accumulator saturates at +2^(ACC_WIDTH−1)−1 / −2^(ACC_WIDTH−1) and does not wrap.
  - Undefined: two's-complement wrap; no saturation logic.
  - The dump value is the saturated or wrapped accumulator accordingly.

## Structure
- Package boc_trk_pkg holds:
  - sample width constant (16);
  - default ACC_WIDTH;
  - state enum {WAIT_SOP, ACC};
  - epoch counter width (16).
- Sub-module boc_trk_acc: one signed lane with inputs sample, chip, clr, load, add; it contains the saturation logic under BOC_TRK_SAT_EN. It is instantiated six times.
- The top level holds the delay line, the period counter/FSM, the output registers and the handshake.

## Test plan
- Sign mapping: SRC_DLY=0, INT_EPOCHS=1, constant real=100, imag=−50, E=0, P=1, L=0, sop every 8 cycles. After the first full period expect ie=800, qe=−400, ip=−800, qp=400, il=800, ql=−400; valid 1 cycle after the second sop.
- Multi-epoch: INT_EPOCHS=3, SRC_DLY=2, sop every 4 cycles, real=1. The first dump equals 12, valid rises 3 cycles after the 4th sop, and tx_epoch_cnt=1.
- Backpressure/overflow: hold ready=0 across two dumps. Valid stays 1, data equals the second dump, tx_ovf=1. With ready=1 on the same cycle as the dump, the new data loads, valid stays 1 and tx_ovf is unchanged.
- Restart: assert rx_trk_rst mid-period coincident with an aligned sop. Valid, tx_ovf and tx_epoch_cnt clear and that sop is ignored; the next sop restarts integration, giving the first dump one full INT_EPOCHS later.
- Saturation: ACC_WIDTH=17, real=32767, chip 0, 8 cycles. With BOC_TRK_SAT_EN defined, ip=65535; without it, ip wraps to a negative value matching the modular reference model.
- Async reset: deassert rx_rst_n mid-integration. All outputs are 0 immediately; no dump occurs until two sops after release.

Source files
------------

// File: rtl/boc_trk_pkg.sv
// Shared constants and types for the B1 BOC early/prompt/late tracking correlator.
package boc_trk_pkg;

  localparam int unsigned SampleWidth = 16;
  localparam int unsigned DefAccWidth = 32;
  localparam int unsigned EpochWidth  = 16;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    ACC      = 1'b1
  } trk_state_e;

endpackage

// File: rtl/boc_trk_acc.sv
// One signed correlator lane: accumulates +sample or -sample depending on the local chip.
// Build option BOC_TRK_SAT_EN: saturate at the ACC_WIDTH limits instead of wrapping.
module boc_trk_acc
  import boc_trk_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DefAccWidth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [SampleWidth-1:0] sample,
  input  logic                          chip,
  input  logic                          clr,
  input  logic                          load,
  input  logic                          add,
  output logic signed [ACC_WIDTH-1:0]   acc
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sample_ext, term, sum;

  assign sample_ext = {{(ACC_WIDTH-SampleWidth){sample[SampleWidth-1]}}, sample};
  // chip 0 -> +1, chip 1 -> -1; negating -32768 is exact because ACC_WIDTH > 16
  assign term = chip ? -sample_ext : sample_ext;

`ifdef BOC_TRK_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_wide;

  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};

  // The two top bits differ only when the true sum left the ACC_WIDTH range
  always_comb begin
    if (sum_wide[ACC_WIDTH] == sum_wide[ACC_WIDTH-1]) begin
      sum = sum_wide[ACC_WIDTH-1:0];
    end else if (sum_wide[ACC_WIDTH]) begin
      sum = AccMin;
    end else begin
      sum = AccMax;
    end
  end
`else
  assign sum = acc_q + term;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = term;
    end else if (add) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/boc_trk_corr.sv
// B1 BOC E/P/L tracking correlator: code alignment delay, epoch FSM, six lanes, dump handshake.
// Build option BOC_TRK_SAT_EN selects saturating lanes (see boc_trk_acc).
module boc_trk_corr
  import boc_trk_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned SRC_DLY    = 2,
  parameter int unsigned INT_EPOCHS = 1
) (
  input  logic                          rx_clk,
  input  logic                          rx_rst_n,
  input  logic signed [SampleWidth-1:0] rx_src_real,
  input  logic signed [SampleWidth-1:0] rx_src_imag,
  input  logic                          rx_loc_bocE,
  input  logic                          rx_loc_bocP,
  input  logic                          rx_loc_bocL,
  input  logic                          rx_prn_sop,
  input  logic                          rx_trk_rst,
  input  logic                          rx_dump_ready,
  output logic signed [ACC_WIDTH-1:0]   tx_ie,
  output logic signed [ACC_WIDTH-1:0]   tx_qe,
  output logic signed [ACC_WIDTH-1:0]   tx_ip,
  output logic signed [ACC_WIDTH-1:0]   tx_qp,
  output logic signed [ACC_WIDTH-1:0]   tx_il,
  output logic signed [ACC_WIDTH-1:0]   tx_ql,
  output logic                          tx_dump_valid,
  output logic [EpochWidth-1:0]         tx_epoch_cnt,
  output logic                          tx_ovf
);

  localparam int unsigned PerWidth = 5;
  localparam logic [PerWidth-1:0] IntEp = PerWidth'(INT_EPOCHS);

  // Delay line: {L, P, E, sop, trk_rst}
  logic [4:0] code_in, code_al;
  logic [2:0] chip_al;
  logic       sop_al, trk_al;

  assign code_in = {rx_loc_bocL, rx_loc_bocP, rx_loc_bocE, rx_prn_sop, rx_trk_rst};

  if (SRC_DLY == 0) begin : g_no_dly
    assign code_al = code_in;
  end else begin : g_dly
    logic [4:0] pipe_q [SRC_DLY];

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
        for (int i = 0; i < SRC_DLY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= code_in;
        for (int i = 1; i < SRC_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign code_al = pipe_q[SRC_DLY-1];
  end

  assign chip_al = code_al[4:2];
  assign sop_al  = code_al[1];
  assign trk_al  = code_al[0];

  trk_state_e          state_q, state_d;
  logic [PerWidth-1:0] per_q, per_d;
  logic                clr, load, add, dump;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    clr     = 1'b0;
    load    = 1'b0;
    add     = 1'b0;
    dump    = 1'b0;
    if (trk_al) begin
      // Restart wins over a coincident sop
      clr     = 1'b1;
      per_d   = '0;
      state_d = WAIT_SOP;
    end else begin
      unique case (state_q)
        WAIT_SOP: begin
          if (sop_al) begin
            load    = 1'b1;
            per_d   = PerWidth'(1);
            state_d = ACC;
          end else begin
            clr = 1'b1;
          end
        end
        ACC: begin
          if (sop_al && (per_q == IntEp)) begin
            // Dump excludes the sop sample, which seeds the next integration
            dump  = 1'b1;
            load  = 1'b1;
            per_d = PerWidth'(1);
          end else begin
            add = 1'b1;
            if (sop_al) per_d = per_q + PerWidth'(1);
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= WAIT_SOP;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
    end
  end

  // Lane order: IE, QE, IP, QP, IL, QL
  logic signed [ACC_WIDTH-1:0] acc_val [6];

  for (genvar i = 0; i < 6; i++) begin : g_lane
    boc_trk_acc #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_acc (
      .clk   (rx_clk),
      .rst_n (rx_rst_n),
      .sample((i % 2 == 0) ? rx_src_real : rx_src_imag),
      .chip  (chip_al[i/2]),
      .clr   (clr),
      .load  (load),
      .add   (add),
      .acc   (acc_val[i])
    );
  end

  logic signed [ACC_WIDTH-1:0] data_q [6];
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;
  logic [EpochWidth-1:0]       epoch_q, epoch_d;

  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    epoch_d = epoch_q;
    if (trk_al) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      epoch_d = '0;
    end else begin
      if (dump) begin
        valid_d = 1'b1;
        epoch_d = epoch_q + EpochWidth'(1);
        if (valid_q && !rx_dump_ready) ovf_d = 1'b1;
      end else if (valid_q && rx_dump_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int i = 0; i < 6; i++) data_q[i] <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      epoch_q <= '0;
    end else begin
      if (dump) begin
        for (int i = 0; i < 6; i++) data_q[i] <= acc_val[i];
      end
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      epoch_q <= epoch_d;
    end
  end

  assign tx_ie         = data_q[0];
  assign tx_qe         = data_q[1];
  assign tx_ip         = data_q[2];
  assign tx_qp         = data_q[3];
  assign tx_il         = data_q[4];
  assign tx_ql         = data_q[5];
  assign tx_dump_valid = valid_q;
  assign tx_epoch_cnt  = epoch_q;
  assign tx_ovf        = ovf_q;

endmodule

// File: tb/tb_boc_trk_corr.sv
// Scoreboard bench for boc_trk_corr: instance A (17-bit, no delay, 1 epoch) and
// instance B (32-bit, 2-cycle delay, 3 epochs); a monitor per instance pops on each new dump.
module tb_boc_trk_corr;

  typedef struct {
    longint ie, qe, ip, qp, il, ql;
    int     ep;
    bit     ovf;
  } exp_t;

`ifdef BOC_TRK_SAT_EN
  localparam longint SatExp = 65535;
`else
  localparam longint SatExp = -8;  // 8*32767 mod 2^17, as signed 17-bit
`endif

  logic clk;
  logic rst_n;

  logic signed [15:0] a_real, a_imag, b_real, b_imag;
  logic a_e, a_p, a_l, a_sop, a_trk, a_ready;
  logic b_e, b_p, b_l, b_sop, b_trk, b_ready;
  logic signed [16:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic signed [31:0] b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic a_valid, a_ovf, b_valid, b_ovf;
  logic [15:0] a_ep, b_ep, a_last_ep, b_last_ep;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t a_q[$];
  exp_t b_q[$];

  boc_trk_corr #(.ACC_WIDTH(17), .SRC_DLY(0), .INT_EPOCHS(1)) u_dut_a (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_src_real(a_real), .rx_src_imag(a_imag),
    .rx_loc_bocE(a_e), .rx_loc_bocP(a_p), .rx_loc_bocL(a_l), .rx_prn_sop(a_sop),
    .rx_trk_rst(a_trk), .rx_dump_ready(a_ready), .tx_ie(a_ie), .tx_qe(a_qe), .tx_ip(a_ip),
    .tx_qp(a_qp), .tx_il(a_il), .tx_ql(a_ql), .tx_dump_valid(a_valid), .tx_epoch_cnt(a_ep),
    .tx_ovf(a_ovf)
  );

  boc_trk_corr #(.ACC_WIDTH(32), .SRC_DLY(2), .INT_EPOCHS(3)) u_dut_b (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_src_real(b_real), .rx_src_imag(b_imag),
    .rx_loc_bocE(b_e), .rx_loc_bocP(b_p), .rx_loc_bocL(b_l), .rx_prn_sop(b_sop),
    .rx_trk_rst(b_trk), .rx_dump_ready(b_ready), .tx_ie(b_ie), .tx_qe(b_qe), .tx_ip(b_ip),
    .tx_qp(b_qp), .tx_il(b_il), .tx_ql(b_ql), .tx_dump_valid(b_valid), .tx_epoch_cnt(b_ep),
    .tx_ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic sb_cmp(input string tag, input exp_t e,
                        input logic signed [63:0] ie, qe, ip, qp, il, ql,
                        input logic [15:0] ep, input logic ovf);
    check({tag, "_ie"}, ie, e.ie);
    check({tag, "_qe"}, qe, e.qe);
    check({tag, "_ip"}, ip, e.ip);
    check({tag, "_qp"}, qp, e.qp);
    check({tag, "_il"}, il, e.il);
    check({tag, "_ql"}, ql, e.ql);
    check({tag, "_epoch"}, {48'd0, ep}, e.ep);
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
  endtask

  task automatic push_a(input longint ie, qe, ip, qp, il, ql, input int ep, input bit ovf);
    exp_t e;
    e.ie = ie; e.qe = qe; e.ip = ip; e.qp = qp; e.il = il; e.ql = ql; e.ep = ep; e.ovf = ovf;
    a_q.push_back(e);
  endtask

  task automatic push_b(input longint ie, qe, ip, qp, il, ql, input int ep, input bit ovf);
    exp_t e;
    e.ie = ie; e.qe = qe; e.ip = ip; e.qp = qp; e.il = il; e.ql = ql; e.ep = ep; e.ovf = ovf;
    b_q.push_back(e);
  endtask

  // A new dump is visible whenever valid is high and the epoch counter just moved
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_valid && (a_ep != a_last_ep)) begin
      if (a_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_sb_unexpected: got dump epoch %0d, expected none", a_ep);
      end else begin
        e = a_q.pop_front();
        sb_cmp("a_sb", e, a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_ep, a_ovf);
      end
    end
    a_last_ep <= a_ep;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_valid && (b_ep != b_last_ep)) begin
      if (b_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_sb_unexpected: got dump epoch %0d, expected none", b_ep);
      end else begin
        e = b_q.pop_front();
        sb_cmp("b_sb", e, b_ie, b_qe, b_ip, b_qp, b_il, b_ql, b_ep, b_ovf);
      end
    end
    b_last_ep <= b_ep;
  end

  task automatic a_cycle(input logic sop, input int re, input int im,
                         input logic e, input logic p, input logic l, input logic rdy);
    @(negedge clk);
    a_sop = sop; a_real = re[15:0]; a_imag = im[15:0];
    a_e = e; a_p = p; a_l = l; a_ready = rdy;
  endtask

  initial begin
    a_last_ep = '0; b_last_ep = '0;
    rst_n = 1'b0;
    {a_e, a_p, a_l, a_sop, a_trk, a_ready} = '0;
    {b_e, b_p, b_l, b_sop, b_trk, b_ready} = '0;
    a_real = '0; a_imag = '0;
    b_real = 16'sd1; b_imag = '0;
    repeat (2) @(negedge clk);
    check("a_rst_valid", a_valid, 0);
    check("a_rst_ovf", a_ovf, 0);
    check("a_rst_epoch", a_ep, 0);
    check("a_rst_ip", a_ip, 0);
    check("b_rst_valid", b_valid, 0);
    check("b_rst_ie", b_ie, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: multi-epoch integration, backpressure, restart coincident with sop
    for (int cyc = 0; cyc <= 50; cyc++) begin
      if (cyc == 12) push_b(12, 0, 12, 0, 12, 0, 1, 0);
      if (cyc == 24) push_b(12, 0, 12, 0, 12, 0, 2, 1);
      if (cyc == 44) push_b(12, 0, 12, 0, 12, 0, 1, 0);
      @(negedge clk);
      b_sop   = (cyc % 4 == 0) && (cyc <= 44);
      b_trk   = (cyc == 28);
      b_ready = (cyc < 12) || (cyc >= 32);
      case (cyc)
        14: check("b_valid_before_lat", b_valid, 0);
        15: begin
          check("b_valid_lat", b_valid, 1);
          check("b_epoch_first", b_ep, 1);
        end
        30: begin
          check("b_valid_held", b_valid, 1);
          check("b_ovf_set", b_ovf, 1);
        end
        31: begin
          check("b_trk_valid", b_valid, 0);
          check("b_trk_ovf", b_ovf, 0);
          check("b_trk_epoch", b_ep, 0);
        end
        44: check("b_restart_no_early", b_valid, 0);
        46: check("b_restart_pre", b_valid, 0);
        47: begin
          check("b_restart_dump", b_valid, 1);
          check("b_restart_epoch", b_ep, 1);
        end
        default: ;
      endcase
    end
    b_sop = 1'b0; b_trk = 1'b0;

    // Instance A: sign mapping
    for (int i = 0; i < 8; i++) a_cycle(i == 0, 100, -50, 0, 1, 0, 1);
    push_a(800, -400, -800, 400, 800, -400, 1, 0);
    for (int i = 0; i < 8; i++) begin
      a_cycle(i == 0, 10, 20, 0, 0, 0, 1);
      if (i == 0) check("a_valid_pre", a_valid, 0);
      if (i == 1) check("a_valid_lat", a_valid, 1);
    end
    // Backpressure: two dumps while ready is low
    push_a(80, 160, 80, 160, 80, 160, 2, 0);
    for (int i = 0; i < 8; i++) a_cycle(i == 0, -3, 7, 1, 1, 1, 0);
    push_a(24, -56, 24, -56, 24, -56, 3, 1);
    for (int i = 0; i < 4; i++) begin
      a_cycle(i == 0, 5, 5, 0, 1, 0, 0);
      if (i == 2) begin
        check("a_ovf_valid", a_valid, 1);
        check("a_ovf_flag", a_ovf, 1);
        check("a_ovf_data", a_ip, 24);
      end
    end
    // Dump coincident with accept; this period also drives the saturation case
    push_a(20, 20, -20, -20, 20, 20, 4, 1);
    for (int i = 0; i < 8; i++) begin
      a_cycle(i == 0, 32767, 0, 0, 0, 0, 1);
      if (i == 1) begin
        check("a_acc_dump_valid", a_valid, 1);
        check("a_acc_dump_ovf", a_ovf, 1);
      end
      if (i == 2) check("a_accept_drop", a_valid, 0);
    end
    push_a(SatExp, 0, SatExp, 0, SatExp, 0, 5, 1);
    a_cycle(1, 1, 1, 0, 0, 0, 1);
    a_cycle(0, 1, 1, 0, 0, 0, 1);
    // Async reset mid-integration
    #2 rst_n = 1'b0;
    #1;
    check("a_arst_valid", a_valid, 0);
    check("a_arst_ovf", a_ovf, 0);
    check("a_arst_epoch", a_ep, 0);
    check("a_arst_ie", a_ie, 0);
    check("a_arst_ip", a_ip, 0);
    check("a_arst_ql", a_ql, 0);
    a_cycle(0, 0, 0, 0, 0, 0, 1);
    a_cycle(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_cycle(i == 0, 2, -2, 0, 0, 1, 1);
      if (i == 1) check("a_post_rst_sop1", a_valid, 0);
      if (i == 7) begin
        check("a_post_rst_nodump", a_valid, 0);
        check("a_post_rst_epoch", a_ep, 0);
      end
    end
    push_a(16, -16, 16, -16, -16, 16, 1, 0);
    a_cycle(1, 0, 0, 0, 0, 0, 1);
    a_cycle(0, 0, 0, 0, 0, 0, 1);
    check("a_post_rst_dump", a_valid, 1);
    for (int i = 0; i < 4; i++) a_cycle(0, 0, 0, 0, 0, 0, 1);

    check("a_sb_drained", a_q.size(), 0);
    check("b_sb_drained", b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
